// File: rtl/transmit_seq_gen.sv
// Transmit-line sequencer: one firing = PR/RX/QUIET/END/GAP/ENV windows on a shared timebase,
// stepping focus then line, with single-frame, continuous and graceful-stop operation.
module transmit_seq_gen #(
  parameter int CNT_W     = 32,
  parameter int NUM_FOCUS = 4,
  parameter int FOCUS_W   = 2,
  parameter int LINES     = 128,
  parameter int LINE_W    = 8,
  parameter int PR_CYC    = 3000,
  parameter int RX_CYC    = 250,
  parameter int END_CYC   = 80,
  parameter int GAP_CYC   = 10,
  parameter int ENV_CYC   = 5
) (
  input  logic                       clk_100M,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       continuous,
  input  logic [NUM_FOCUS*CNT_W-1:0] period_tbl,
  output logic [LINE_W-1:0]          line_num,
  output logic [FOCUS_W-1:0]         focus_num,
  output logic                       pr_gate,
  output logic                       rx_gate,
  output logic                       end_gate,
  output logic                       envelop,
  output logic                       busy,
  output logic                       frame_done
);

  // state | meaning
  // IDLE  | waiting for start      PR  | transmit window    RX  | receive window
  // QUIET | pad up to line period  END | end-of-line window GAP | idle before envelop
  // ENV   | firing-complete strobe; last cycle advances focus/line or returns to IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_PR, S_RX, S_QUIET, S_END, S_GAP, S_ENV
  } state_t;

  // Two spare bits keep Peff + END + GAP + ENV from wrapping.
  localparam int TW = CNT_W + 2;
  localparam logic [TW-1:0] C_ONE     = TW'(1);
  localparam logic [TW-1:0] C_PR_LAST = TW'(PR_CYC - 1);
  localparam logic [TW-1:0] C_RX_LAST = TW'(PR_CYC + RX_CYC - 1);
  localparam logic [TW-1:0] C_PRRX    = TW'(PR_CYC + RX_CYC);
  localparam logic [TW-1:0] C_END     = TW'(END_CYC);
  localparam logic [TW-1:0] C_GAP     = TW'(GAP_CYC);
  localparam logic [TW-1:0] C_ENV     = TW'(ENV_CYC);

  state_t r_state, w_state_nxt;

  logic [TW-1:0]      r_t, w_t_nxt;
  logic [TW-1:0]      r_peff, w_peff_nxt;
  logic [TW-1:0]      w_quiet_last, w_end_last, w_gap_last, w_env_last;
  logic [CNT_W-1:0]   w_period_sel;
  logic [FOCUS_W-1:0] r_focus, w_focus_nxt;
  logic [LINE_W-1:0]  r_line, w_line_nxt;
  logic               r_stop, w_stop_any, w_load;
  logic               w_focus_wrap, w_line_wrap, w_last;
  logic               r_pr, r_rx, r_end, r_env, r_busy, r_frame_done;

  assign w_quiet_last = r_peff - C_ONE;
  assign w_end_last   = r_peff + C_END - C_ONE;
  assign w_gap_last   = r_peff + C_END + C_GAP - C_ONE;
  assign w_env_last   = r_peff + C_END + C_GAP + C_ENV - C_ONE;

  assign w_focus_wrap = (r_focus == FOCUS_W'(NUM_FOCUS - 1));
  assign w_line_wrap  = (r_line == LINE_W'(LINES - 1));
  assign w_last       = w_focus_wrap && w_line_wrap;
  assign w_stop_any   = r_stop | stop;

  // Period is looked up with the index the upcoming firing will use.
  always_comb begin
    w_period_sel = '0;
    for (int f = 0; f < NUM_FOCUS; f++) begin
      if (w_focus_nxt == FOCUS_W'(f)) begin
        w_period_sel = period_tbl[f*CNT_W +: CNT_W];
      end
    end
  end

  assign w_peff_nxt = (TW'(w_period_sel) > C_PRRX) ? TW'(w_period_sel) : C_PRRX;

  always_comb begin
    w_state_nxt = r_state;
    w_focus_nxt = r_focus;
    w_line_nxt  = r_line;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_PR;
          w_focus_nxt = '0;
          w_line_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      S_PR: begin
        if (r_t == C_PR_LAST) w_state_nxt = S_RX;
      end
      S_RX: begin
        if (r_t == C_RX_LAST) w_state_nxt = (r_peff > C_PRRX) ? S_QUIET : S_END;
      end
      S_QUIET: begin
        if (r_t == w_quiet_last) w_state_nxt = S_END;
      end
      S_END: begin
        if (r_t == w_end_last) w_state_nxt = (GAP_CYC > 0) ? S_GAP : S_ENV;
      end
      S_GAP: begin
        if (r_t == w_gap_last) w_state_nxt = S_ENV;
      end
      S_ENV: begin
        if (r_t == w_env_last) begin
          if (w_last) begin
            if (continuous && !w_stop_any) begin
              w_state_nxt = S_PR;
              w_focus_nxt = '0;
              w_line_nxt  = '0;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (w_stop_any) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_PR;
            w_focus_nxt = w_focus_wrap ? '0 : r_focus + FOCUS_W'(1);
            w_line_nxt  = w_focus_wrap ? r_line + LINE_W'(1) : r_line;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_t_nxt = (w_load || (w_state_nxt == S_IDLE)) ? '0 : r_t + C_ONE;

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_t          <= '0;
      r_peff       <= '0;
      r_focus      <= '0;
      r_line       <= '0;
      r_stop       <= 1'b0;
      r_pr         <= 1'b0;
      r_rx         <= 1'b0;
      r_end        <= 1'b0;
      r_env        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      if (w_load) r_peff <= w_peff_nxt;
      r_focus      <= w_focus_nxt;
      r_line       <= w_line_nxt;
      r_stop       <= (w_state_nxt == S_IDLE) ? 1'b0 : (r_stop | (stop && (r_state != S_IDLE)));
      r_pr         <= (w_state_nxt == S_PR);
      r_rx         <= (w_state_nxt == S_RX);
      r_end        <= (w_state_nxt == S_END);
      r_env        <= (w_state_nxt == S_ENV);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_ENV) && (w_t_nxt == w_env_last) && w_last;
    end
  end

  assign line_num   = r_line;
  assign focus_num  = r_focus;
  assign pr_gate    = r_pr;
  assign rx_gate    = r_rx;
  assign end_gate   = r_end;
  assign envelop    = r_env;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_transmit_seq_gen.sv
// Scoreboard bench for transmit_seq_gen: stimulus pushes expected firings, a negedge monitor
// reconstructs each firing's timing and compares it when envelop is seen.
module tb_transmit_seq_gen;
  localparam int CNT_W = 16;
  localparam int NF    = 2;
  localparam int FW    = 2;
  localparam int LN    = 3;
  localparam int LW    = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               cont;
  logic [NF*CNT_W-1:0] ptbl;
  logic [LW-1:0]      line_num;
  logic [FW-1:0]      focus_num;
  logic               pr, rx, eg, env, busy, fd;

  transmit_seq_gen #(
    .CNT_W(CNT_W), .NUM_FOCUS(NF), .FOCUS_W(FW), .LINES(LN), .LINE_W(LW),
    .PR_CYC(4), .RX_CYC(2), .END_CYC(2), .GAP_CYC(1), .ENV_CYC(1)
  ) dut (
    .clk_100M(clk), .reset_n(rst_n), .start(start), .stop(stop), .continuous(cont),
    .period_tbl(ptbl), .line_num(line_num), .focus_num(focus_num),
    .pr_gate(pr), .rx_gate(rx), .end_gate(eg), .envelop(env), .busy(busy), .frame_done(fd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int line;
    int focus;
    int end_t;
    int env_t;
    int fd;
    int b2b;
  } rec_t;

  rec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   fd_total = 0;
  int   excl_viol = 0;
  int   fd_viol = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_rec(input int l, input int f, input int end_t, input int fdv, input int b2b);
    rec_t r;
    r.line = l; r.focus = f; r.end_t = end_t; r.env_t = end_t + 3; r.fd = fdv; r.b2b = b2b;
    sb_q.push_back(r);
  endtask

  // e0/e1: end_gate start offset (clamped period) for focus 0/1
  task automatic push_frame(input int e0, input int e1, input int b2b_first);
    for (int l = 0; l < LN; l++) begin
      for (int f = 0; f < NF; f++) begin
        push_rec(l, f, (f == 0) ? e0 : e1, (l == LN-1 && f == NF-1) ? 1 : 0,
                 (l == 0 && f == 0) ? b2b_first : 1);
      end
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    @(posedge clk); #1 start = s; stop = p;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic measure_busy(input int budget, output int len);
    len = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      len++;
      if (len >= budget) begin
        checks++; errors++;
        $display("FAIL busy_timeout: busy still high after %0d cycles, required to drop", len);
        break;
      end
    end
  endtask

  // Monitor: rebuild firing timing relative to pr_gate rise
  initial begin : monitor
    int cyc, st, last_env, pr_n, rx_n, rx_t, end_t, ln, fc, b2b;
    logic p_pr, p_rx, p_end;
    rec_t e;
    cyc = 0; st = 0; last_env = -10; pr_n = 0; rx_n = 0; rx_t = -1; end_t = -1;
    ln = 0; fc = 0; b2b = 0; p_pr = 0; p_rx = 0; p_end = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pr && !p_pr) begin
        st = cyc; b2b = (last_env == cyc - 1) ? 1 : 0;
        pr_n = 0; rx_n = 0; rx_t = -1; end_t = -1;
        ln = int'(line_num); fc = int'(focus_num);
      end
      if (pr) pr_n++;
      if (rx) begin
        if (!p_rx) rx_t = cyc - st;
        rx_n++;
      end
      if (eg && !p_end) end_t = cyc - st;
      if ($countones({pr, rx, eg, env}) > 1) excl_viol++;
      if (fd) begin
        fd_total++;
        if (!env) fd_viol++;
      end
      if (env) begin
        last_env = cyc;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_firing: got envelop for line=%0d focus=%0d, expected none", ln, fc);
        end else begin
          e = sb_q.pop_front();
          if (ln != e.line || fc != e.focus || pr_n != 4 || rx_t != 4 || rx_n != 2 ||
              end_t != e.end_t || (cyc - st) != e.env_t || int'(fd) != e.fd || b2b != e.b2b) begin
            errors++;
            $display("FAIL firing: got line=%0d focus=%0d pr=%0d rx_t=%0d rx=%0d end_t=%0d env_t=%0d fd=%0d b2b=%0d, expected line=%0d focus=%0d pr=4 rx_t=4 rx=2 end_t=%0d env_t=%0d fd=%0d b2b=%0d",
                     ln, fc, pr_n, rx_t, rx_n, end_t, cyc - st, int'(fd), b2b,
                     e.line, e.focus, e.end_t, e.env_t, e.fd, e.b2b);
          end
        end
      end
      p_pr = pr; p_rx = rx; p_end = eg;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int len, fd0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    ptbl = {16'd20, 16'd10};
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", int'({line_num, focus_num, pr, rx, eg, env, busy, fd}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single frame, periods 10/20
    push_frame(10, 20, 0);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    measure_busy(2000, len);
    check("t1_frame_len", len, 114);
    check("t1_frame_done", fd_total - fd0, 1);
    check("t1_busy_low", int'(busy), 0);
    check("t1_line_hold", int'(line_num), 2);
    check("t1_focus_hold", int'(focus_num), 1);
    check("t1_sb_empty", sb_q.size(), 0);

    // focus 0 period below PR+RX is clamped to 6
    ptbl = {16'd20, 16'd3};
    push_frame(6, 20, 0);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    measure_busy(2000, len);
    check("t2_frame_len", len, 102);
    check("t2_frame_done", fd_total - fd0, 1);

    // continuous: two frames back to back, stop during last firing of frame 2
    cont = 1'b1;
    ptbl = {16'd10, 16'd10};
    push_frame(10, 10, 0);
    push_frame(10, 10, 1);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    fork
      measure_busy(2000, len);
      begin
        repeat (158) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
      end
    join
    cont = 1'b0;
    check("t3_run_len", len, 168);
    check("t3_frame_done", fd_total - fd0, 2);
    check("t3_sb_empty", sb_q.size(), 0);

    // stop at t=5 of line 1 focus 0
    ptbl = {16'd20, 16'd10};
    push_rec(0, 0, 10, 0, 0);
    push_rec(0, 1, 20, 0, 1);
    push_rec(1, 0, 10, 0, 1);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    fork
      measure_busy(2000, len);
      begin
        repeat (43) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
      end
    join
    check("t4_run_len", len, 52);
    check("t4_no_frame_done", fd_total - fd0, 0);
    check("t4_line_hold", int'(line_num), 1);
    check("t4_focus_hold", int'(focus_num), 0);
    check("t4_sb_empty", sb_q.size(), 0);

    // asynchronous reset during RX, then a fresh frame
    pulse(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("t5_in_rx", int'(rx), 1);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", int'({line_num, focus_num, pr, rx, eg, env, busy, fd}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    push_frame(10, 20, 0);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    measure_busy(2000, len);
    check("t5_frame_len", len, 114);
    check("t5_frame_done", fd_total - fd0, 1);

    // start+stop in IDLE ignored; start while busy ignored
    pulse(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_startstop_busy", int'(busy), 0);
    check("t6_startstop_pr", int'(pr), 0);
    push_frame(10, 20, 0);
    fd0 = fd_total;
    pulse(1'b1, 1'b0);
    fork
      measure_busy(2000, len);
      begin
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    check("t6_frame_len", len, 114);
    check("t6_frame_done", fd_total - fd0, 1);

    repeat (3) @(negedge clk);
    check("exclusive_gates", excl_viol, 0);
    check("frame_done_outside_env", fd_viol, 0);
    check("sb_empty_final", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
